// File: rtl/mem_arb_pkg.sv
//==============================================================================
// Package : mem_arb_pkg
// Shared encodings for the memory request arbiter: FSM states, transaction
// owner, and the beat-counter width helper.
// Revision: 1.0
//==============================================================================
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CMD     = 2'd1,
    ST_RD_DATA = 2'd2,
    ST_WR_DATA = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_t;

  // Width of a counter that indexes beats within one cache line.
  function automatic int beat_cnt_w(input int line_beats);
    return (line_beats > 1) ? $clog2(line_beats) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_rr_arbiter.sv
//==============================================================================
// Module  : mem_rr_arbiter
// Two-way round-robin arbiter between icache and dcache. A sole requester
// wins; on a tie the requester that did not win last time is granted.
// Revision: 1.0
//==============================================================================
`default_nettype none

module mem_rr_arbiter
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,       // asynchronous, active-low
  input  logic req_ic,
  input  logic req_dc,
  input  logic en,        // grants only issued while the arbiter may accept
  output logic grant_ic,
  output logic grant_dc
);

  owner_t last_grant;

  // Grant decision: sole requester wins, ties go to the one not granted last.
  always_comb begin
    grant_ic = 1'b0;
    grant_dc = 1'b0;
    if (en) begin
      if (req_ic && req_dc) begin
        if (last_grant == OWN_IC) grant_dc = 1'b1;
        else                      grant_ic = 1'b1;
      end else begin
        grant_ic = req_ic;
        grant_dc = req_dc;
      end
    end
  end

  // Remember the most recent winner; reset favours DC on the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          last_grant <= OWN_IC;
    else if (grant_dc) last_grant <= OWN_DC;
    else if (grant_ic) last_grant <= OWN_IC;
  end

endmodule

`default_nettype wire

// File: rtl/mem_req_arbiter.sv
//==============================================================================
// Module  : mem_req_arbiter
// Arbitrates icache/dcache line refills and dcache writebacks onto a single
// burst memory port, one transaction outstanding, and drives the CPU stall.
// Revision: 1.0
//==============================================================================
`default_nettype none

module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 128,
  parameter int LINE_BEATS = 4
) (
  input  logic              clk,
  input  logic              rst,            // asynchronous, active-low
  input  logic              ic_req_valid,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_req_ready,
  input  logic              dc_req_valid,
  input  logic              dc_req_we,
  input  logic [ADDR_W-1:0] dc_req_addr,
  output logic              dc_req_ready,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_wdata_ready,
  output logic [DATA_W-1:0] ic_rdata,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              ic_rvalid,
  output logic              dc_rvalid,
  output logic              ic_rlast,
  output logic              dc_rlast,
  output logic              mem_req_valid,
  output logic              mem_req_rnw,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  output logic              mem_wdata_valid,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_wdata_ready,
  input  logic              mem_rdata_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  localparam int                CNT_W      = beat_cnt_w(LINE_BEATS);
  localparam int                OFF_W      = $clog2(LINE_BEATS * DATA_W / 8);
  localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(LINE_BEATS - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << OFF_W;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  beat_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              rnw_q;
  owner_t            owner_q;

  logic grant_ic;
  logic grant_dc;
  logic in_idle;
  logic in_cmd;
  logic in_rd;
  logic in_wr;
  logic rd_beat;
  logic wr_beat;

  // No grant can be issued while reset is held, so every output is quiet.
  assign in_idle = (state == ST_IDLE) && rst;
  assign in_cmd  = (state == ST_CMD);
  assign in_rd   = (state == ST_RD_DATA);
  assign in_wr   = (state == ST_WR_DATA);
  assign rd_beat = in_rd && mem_rdata_valid;
  assign wr_beat = in_wr && mem_wdata_ready;

  mem_rr_arbiter u_rr (
    .clk      (clk),
    .rst      (rst),
    .req_ic   (ic_req_valid),
    .req_dc   (dc_req_valid),
    .en       (in_idle),
    .grant_ic (grant_ic),
    .grant_dc (grant_dc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode: IDLE -> CMD -> RD_DATA/WR_DATA -> IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (grant_ic || grant_dc)                state_nxt = ST_CMD;
      ST_CMD:     if (mem_req_ready)                       state_nxt = rnw_q ? ST_RD_DATA : ST_WR_DATA;
      ST_RD_DATA: if (rd_beat && (beat_cnt == LAST_BEAT))  state_nxt = ST_IDLE;
      ST_WR_DATA: if (wr_beat && (beat_cnt == LAST_BEAT))  state_nxt = ST_IDLE;
      default:                                             state_nxt = ST_IDLE;
    endcase
  end

  // Transaction context captured at grant, plus the in-line beat counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt <= '0;
      addr_q   <= '0;
      rnw_q    <= 1'b0;
      owner_q  <= OWN_IC;
    end else begin
      if (state_nxt == ST_IDLE)  beat_cnt <= '0;
      else if (rd_beat || wr_beat) beat_cnt <= beat_cnt + CNT_W'(1);

      if (grant_ic) begin
        addr_q  <= ic_req_addr & ALIGN_MASK;
        rnw_q   <= 1'b1;
        owner_q <= OWN_IC;
      end else if (grant_dc) begin
        addr_q  <= dc_req_addr & ALIGN_MASK;
        rnw_q   <= ~dc_req_we;
        owner_q <= OWN_DC;
      end
    end
  end

  assign ic_req_ready    = grant_ic;
  assign dc_req_ready    = grant_dc;

  assign mem_req_valid   = in_cmd;
  assign mem_req_rnw     = in_cmd & rnw_q;
  assign mem_req_addr    = in_cmd ? addr_q : '0;

  assign mem_wdata_valid = in_wr;
  assign mem_wdata       = in_wr ? dc_wdata : '0;
  assign dc_wdata_ready  = wr_beat;

  // Refill beats pass straight through to the owner with zero latency.
  assign ic_rdata        = in_rd ? mem_rdata : '0;
  assign dc_rdata        = in_rd ? mem_rdata : '0;
  assign ic_rvalid       = rd_beat && (owner_q == OWN_IC);
  assign dc_rvalid       = rd_beat && (owner_q == OWN_DC);
  assign ic_rlast        = ic_rvalid && (beat_cnt == LAST_BEAT);
  assign dc_rlast        = dc_rvalid && (beat_cnt == LAST_BEAT);

  assign stall           = ic_req_valid | dc_req_valid | (state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_req_arbiter.sv
`default_nettype none

module tb_mem_req_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         ic_req_valid;
  logic [31:0]  ic_req_addr;
  logic         ic_req_ready;
  logic         dc_req_valid;
  logic         dc_req_we;
  logic [31:0]  dc_req_addr;
  logic         dc_req_ready;
  logic [127:0] dc_wdata;
  logic         dc_wdata_ready;
  logic [127:0] ic_rdata;
  logic [127:0] dc_rdata;
  logic         ic_rvalid;
  logic         dc_rvalid;
  logic         ic_rlast;
  logic         dc_rlast;
  logic         mem_req_valid;
  logic         mem_req_rnw;
  logic [31:0]  mem_req_addr;
  logic         mem_req_ready;
  logic         mem_wdata_valid;
  logic [127:0] mem_wdata;
  logic         mem_wdata_ready;
  logic         mem_rdata_valid;
  logic [127:0] mem_rdata;
  logic         stall;

  int nvec = 0;
  int nerr = 0;

  mem_req_arbiter #(.ADDR_W(32), .DATA_W(128), .LINE_BEATS(4)) dut (
    .clk(clk), .rst(rst),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
    .dc_req_valid(dc_req_valid), .dc_req_we(dc_req_we), .dc_req_addr(dc_req_addr),
    .dc_req_ready(dc_req_ready), .dc_wdata(dc_wdata), .dc_wdata_ready(dc_wdata_ready),
    .ic_rdata(ic_rdata), .dc_rdata(dc_rdata), .ic_rvalid(ic_rvalid), .dc_rvalid(dc_rvalid),
    .ic_rlast(ic_rlast), .dc_rlast(dc_rlast),
    .mem_req_valid(mem_req_valid), .mem_req_rnw(mem_req_rnw), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready), .mem_wdata_valid(mem_wdata_valid), .mem_wdata(mem_wdata),
    .mem_wdata_ready(mem_wdata_ready), .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
    .stall(stall)
  );

  always #5 clk = ~clk;

  // Inputs change 1 ns after the rising edge; outputs are sampled 3 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ic_req_valid = 0; ic_req_addr = '0;
    dc_req_valid = 0; dc_req_we = 0; dc_req_addr = '0; dc_wdata = '0;
    mem_req_ready = 0; mem_wdata_ready = 0; mem_rdata_valid = 0; mem_rdata = '0;
  endtask

  // Entered in CMD with mem_req_ready low; leaves in IDLE after 4 refill beats.
  task automatic serve_read(input bit to_dc, input logic [31:0] exp_addr);
    logic [127:0] beat;
    mem_req_ready = 1;
    #3;
    nvec++; if ({mem_req_valid, mem_req_rnw, mem_req_addr} !== {2'b11, exp_addr}) begin
      nerr++; $display("FAIL rd_cmd: got valid=%b rnw=%b addr=%h want 1 1 %h", mem_req_valid, mem_req_rnw, mem_req_addr, exp_addr); end
    step();
    mem_req_ready = 0;
    for (int b = 0; b < 4; b++) begin
      beat = {96'h0, exp_addr} + 128'(b);
      mem_rdata_valid = 1; mem_rdata = beat;
      #3;
      nvec++; if ({ic_rvalid, dc_rvalid, ic_rlast, dc_rlast} !== {!to_dc, to_dc, !to_dc && b == 3, to_dc && b == 3}) begin
        nerr++; $display("FAIL rd_beat%0d: got icv=%b dcv=%b icl=%b dcl=%b want owner_dc=%b last=%b",
                         b, ic_rvalid, dc_rvalid, ic_rlast, dc_rlast, to_dc, b == 3); end
      nvec++; if ((to_dc ? dc_rdata : ic_rdata) !== beat) begin
        nerr++; $display("FAIL rd_data%0d: got %h want %h", b, to_dc ? dc_rdata : ic_rdata, beat); end
      step();
    end
    mem_rdata_valid = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 0;
    step();
    step();
    rst = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0;
    #3;
    nvec++; if ({ic_req_ready, dc_req_ready, mem_req_valid, mem_wdata_valid, ic_rvalid, dc_rvalid, stall} !== 7'b0) begin
      nerr++; $display("FAIL reset_ctrl: got %b want 0000000",
                       {ic_req_ready, dc_req_ready, mem_req_valid, mem_wdata_valid, ic_rvalid, dc_rvalid, stall}); end
    nvec++; if (mem_req_addr !== 32'h0) begin
      nerr++; $display("FAIL reset_addr: got %h want 0", mem_req_addr); end
    step();
    rst = 1;
    step();
  endtask

  task automatic test_ic_read();
    ic_req_valid = 1; ic_req_addr = 32'h0000_1010;
    #3;
    nvec++; if ({ic_req_ready, dc_req_ready, stall} !== 3'b101) begin
      nerr++; $display("FAIL ic_grant: got icr=%b dcr=%b stall=%b want 1 0 1", ic_req_ready, dc_req_ready, stall); end
    step();
    ic_req_valid = 0;
    serve_read(1'b0, 32'h0000_1000);
    #3;
    nvec++; if (stall !== 1'b0) begin
      nerr++; $display("FAIL ic_done_stall: got %b want 0", stall); end
    step();
  endtask

  task automatic test_round_robin();
    do_reset();
    // First tie after reset goes to DC.
    ic_req_valid = 1; ic_req_addr = 32'h0000_2000;
    dc_req_valid = 1; dc_req_we = 0; dc_req_addr = 32'h0000_3000;
    #3;
    nvec++; if ({ic_req_ready, dc_req_ready} !== 2'b01) begin
      nerr++; $display("FAIL tie1: got icr=%b dcr=%b want 0 1", ic_req_ready, dc_req_ready); end
    step();
    dc_req_valid = 0;
    serve_read(1'b1, 32'h0000_3000);
    // IC, held through the DC transaction, is granted in the returning IDLE cycle.
    #3;
    nvec++; if ({ic_req_ready, dc_req_ready} !== 2'b10) begin
      nerr++; $display("FAIL b2b_ic: got icr=%b dcr=%b want 1 0", ic_req_ready, dc_req_ready); end
    step();
    ic_req_valid = 0;
    serve_read(1'b0, 32'h0000_2000);
    // DC alone, leaving DC as the last winner.
    dc_req_valid = 1; dc_req_addr = 32'h0000_3040;
    #3;
    nvec++; if ({ic_req_ready, dc_req_ready} !== 2'b01) begin
      nerr++; $display("FAIL dc_alone: got icr=%b dcr=%b want 0 1", ic_req_ready, dc_req_ready); end
    step();
    dc_req_valid = 0;
    serve_read(1'b1, 32'h0000_3040);
    // Tie again: IC now wins, DC follows.
    ic_req_valid = 1; ic_req_addr = 32'h0000_2040;
    dc_req_valid = 1; dc_req_addr = 32'h0000_3080;
    #3;
    nvec++; if ({ic_req_ready, dc_req_ready} !== 2'b10) begin
      nerr++; $display("FAIL tie2: got icr=%b dcr=%b want 1 0", ic_req_ready, dc_req_ready); end
    step();
    ic_req_valid = 0;
    serve_read(1'b0, 32'h0000_2040);
    #3;
    nvec++; if ({ic_req_ready, dc_req_ready} !== 2'b01) begin
      nerr++; $display("FAIL tie2_dc: got icr=%b dcr=%b want 0 1", ic_req_ready, dc_req_ready); end
    step();
    dc_req_valid = 0;
    serve_read(1'b1, 32'h0000_3080);
  endtask

  task automatic test_writeback();
    bit pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int acc = 0;
    dc_req_valid = 1; dc_req_we = 1; dc_req_addr = 32'h0000_0040;
    #3;
    nvec++; if (dc_req_ready !== 1'b1) begin
      nerr++; $display("FAIL wb_grant: got %b want 1", dc_req_ready); end
    step();
    dc_req_valid = 0; dc_req_we = 0;
    mem_req_ready = 1;
    #3;
    nvec++; if ({mem_req_valid, mem_req_rnw, mem_req_addr} !== {2'b10, 32'h0000_0040}) begin
      nerr++; $display("FAIL wb_cmd: got valid=%b rnw=%b addr=%h want 1 0 00000040", mem_req_valid, mem_req_rnw, mem_req_addr); end
    step();
    mem_req_ready = 0;
    for (int i = 0; i < 6; i++) begin
      mem_wdata_ready = pat[i];
      dc_wdata = 128'hD0 + 128'(acc);
      #3;
      nvec++; if ({mem_wdata_valid, dc_wdata_ready} !== {1'b1, pat[i]}) begin
        nerr++; $display("FAIL wb_cyc%0d: got wvalid=%b wready=%b want 1 %b", i, mem_wdata_valid, dc_wdata_ready, pat[i]); end
      nvec++; if (mem_wdata !== 128'hD0 + 128'(acc)) begin
        nerr++; $display("FAIL wb_data%0d: got %h want %h", i, mem_wdata, 128'hD0 + 128'(acc)); end
      if (dc_wdata_ready) acc++;
      step();
    end
    // After four accepted beats the write channel must be closed.
    mem_wdata_ready = 1;
    #3;
    nvec++; if ({mem_wdata_valid, dc_wdata_ready, stall} !== 3'b000) begin
      nerr++; $display("FAIL wb_end: got wvalid=%b wready=%b stall=%b want 0 0 0", mem_wdata_valid, dc_wdata_ready, stall); end
    step();
    mem_wdata_ready = 0; dc_wdata = '0;
  endtask

  task automatic test_cmd_backpressure();
    ic_req_valid = 1; ic_req_addr = 32'h5555_5567;
    #3;
    nvec++; if (ic_req_ready !== 1'b1) begin
      nerr++; $display("FAIL bp_grant: got %b want 1", ic_req_ready); end
    step();
    ic_req_valid = 0;
    for (int i = 0; i < 5; i++) begin
      #3;
      nvec++; if ({mem_req_valid, mem_req_rnw, stall, mem_req_addr} !== {3'b111, 32'h5555_5540}) begin
        nerr++; $display("FAIL bp_hold%0d: got valid=%b rnw=%b stall=%b addr=%h want 1 1 1 55555540",
                         i, mem_req_valid, mem_req_rnw, stall, mem_req_addr); end
      step();
    end
    serve_read(1'b0, 32'h5555_5540);
  endtask

  task automatic test_stray_rdata();
    mem_rdata_valid = 1; mem_rdata = 128'hBAD;
    for (int i = 0; i < 2; i++) begin
      #3;
      nvec++; if ({ic_rvalid, dc_rvalid, stall} !== 3'b000) begin
        nerr++; $display("FAIL stray_idle%0d: got icv=%b dcv=%b stall=%b want 0 0 0", i, ic_rvalid, dc_rvalid, stall); end
      step();
    end
    mem_rdata_valid = 0;
    ic_req_valid = 1; ic_req_addr = 32'h0000_8000;
    step();
    ic_req_valid = 0;
    mem_rdata_valid = 1;
    for (int i = 0; i < 2; i++) begin
      #3;
      nvec++; if ({ic_rvalid, dc_rvalid, mem_req_valid} !== 3'b001) begin
        nerr++; $display("FAIL stray_cmd%0d: got icv=%b dcv=%b reqv=%b want 0 0 1", i, ic_rvalid, dc_rvalid, mem_req_valid); end
      step();
    end
    mem_rdata_valid = 0; mem_rdata = '0;
    // rlast on the fourth real beat shows the counter ignored the stray beats.
    serve_read(1'b0, 32'h0000_8000);
  endtask

  task automatic test_reset_mid();
    ic_req_valid = 1; ic_req_addr = 32'h0000_6000;
    step();
    ic_req_valid = 0;
    mem_req_ready = 1;
    step();
    mem_req_ready = 0;
    for (int b = 0; b < 2; b++) begin
      mem_rdata_valid = 1; mem_rdata = 128'h60 + 128'(b);
      step();
    end
    mem_rdata = 128'h62;
    rst = 0;
    #3;
    nvec++; if ({ic_rvalid, ic_rlast, dc_rvalid, mem_req_valid, mem_wdata_valid, stall} !== 6'b0) begin
      nerr++; $display("FAIL rst_mid: got icv=%b icl=%b dcv=%b reqv=%b wv=%b stall=%b want all 0",
                       ic_rvalid, ic_rlast, dc_rvalid, mem_req_valid, mem_wdata_valid, stall); end
    nvec++; if (ic_rdata !== 128'h0) begin
      nerr++; $display("FAIL rst_mid_data: got %h want 0", ic_rdata); end
    step();
    mem_rdata_valid = 0; mem_rdata = '0;
    rst = 1;
    step();
    ic_req_valid = 1; ic_req_addr = 32'h0000_7000;
    #3;
    nvec++; if (ic_req_ready !== 1'b1) begin
      nerr++; $display("FAIL rst_regrant: got %b want 1", ic_req_ready); end
    step();
    ic_req_valid = 0;
    serve_read(1'b0, 32'h0000_7000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 0;
    #1;
    test_reset();
    test_ic_read();
    test_round_robin();
    test_writeback();
    test_cmd_backpressure();
    test_stray_rdata();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
